// File: rtl/creek_run_sequencer_if.sv
// Avalon-MM control/status link between the run sequencer (master) and the
// creek control adapter (slave): no address bus, fixed read latency of one cycle.
interface creek_run_sequencer_if;
  logic [7:0] ctrl_writedata;
  logic       ctrl_write;
  logic       ctrl_read;
  logic [7:0] ctrl_readdata;

  modport master (
    output ctrl_writedata,
    output ctrl_write,
    output ctrl_read,
    input  ctrl_readdata
  );

  modport slave (
    input  ctrl_writedata,
    input  ctrl_write,
    input  ctrl_read,
    output ctrl_readdata
  );
endinterface

// File: rtl/creek_run_sequencer.sv
// Runs one creek program: pulse reset, release pause, poll the waiting bit,
// then re-pause; reports done/timeout/abort and the run length in cycles.
module creek_run_sequencer #(
  parameter int POLL_INTERVAL = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  timeout_cycles,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  creek_run_sequencer_if.master ctrl
);

  localparam int                   GAP_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(POLL_INTERVAL - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [7:0] WR_RESET = 8'h02;
  localparam logic [7:0] WR_RUN   = 8'h01;
  localparam logic [7:0] WR_HALT  = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_WR,
    S_RUN_WR,
    S_GAP,
    S_POLL_RD,
    S_POLL_WAIT,
    S_HALT_WR,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timed_out_q, timed_out_d;
  logic                 aborted_q, aborted_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 write_q, write_d;
  logic                 read_q, read_d;
  logic [7:0]           wdata_q, wdata_d;

  logic                 waiting;
  logic                 limit_hit;
  logic                 counting;
  logic                 unused_readdata;

  assign waiting         = ctrl.ctrl_readdata[2];
  assign unused_readdata = ^{ctrl.ctrl_readdata[7:3], ctrl.ctrl_readdata[1:0]};
  assign limit_hit       = (timeout_cycles != '0) && (cnt_q >= timeout_cycles);

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    timed_out_d = timed_out_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RESET_WR;
          timed_out_d = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      S_RESET_WR: state_d = S_RUN_WR;
      S_RUN_WR: begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_POLL_RD;
        else             gap_d   = gap_q - GAP_ONE;
      end
      S_POLL_RD: state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (abort) begin
          state_d   = S_HALT_WR;
          aborted_d = 1'b1;
        end else if (waiting) begin
          state_d = S_HALT_WR;
        end else if (limit_hit) begin
          state_d     = S_HALT_WR;
          timed_out_d = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_HALT_WR: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort overrides the pre-poll states; the bus cycle already on the wire completes.
    if (abort && (state_q inside {S_RESET_WR, S_RUN_WR, S_GAP, S_POLL_RD})) begin
      state_d   = S_HALT_WR;
      aborted_d = 1'b1;
    end
  end

  // Count only edges that stay inside the polling phase, so the count freezes at HALT_WR.
  assign counting = (state_q inside {S_GAP, S_POLL_RD, S_POLL_WAIT}) && (state_d != S_HALT_WR);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start) cnt_d = '0;
    else if (counting && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    read_d  = (state_d == S_POLL_RD);
    write_d = 1'b0;
    wdata_d = 8'h00;
    unique case (state_d)
      S_RESET_WR: begin write_d = 1'b1; wdata_d = WR_RESET; end
      S_RUN_WR:   begin write_d = 1'b1; wdata_d = WR_RUN;   end
      S_HALT_WR:  begin write_d = 1'b1; wdata_d = WR_HALT;  end
      default:    begin write_d = 1'b0; wdata_d = 8'h00;    end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      wdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      write_q     <= write_d;
      read_q      <= read_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign timed_out           = timed_out_q;
  assign aborted             = aborted_q;
  assign cycle_count         = cnt_q;
  assign ctrl.ctrl_write     = write_q;
  assign ctrl.ctrl_read      = read_q;
  assign ctrl.ctrl_writedata = wdata_q;

endmodule

// File: tb/tb_creek_run_sequencer.sv
// Randomized bench for creek_run_sequencer: a cycle-indexed schedule of bus
// activity is derived arithmetically per run and compared every cycle.
`timescale 1ns/1ps
module tb_creek_run_sequencer;
  localparam int P  = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] timeout_cycles = '0;
  logic          busy, done, timed_out, aborted;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  creek_run_sequencer_if bus_if ();

  creek_run_sequencer #(.POLL_INTERVAL(P), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .timeout_cycles (timeout_cycles),
    .busy           (busy),
    .done           (done),
    .timed_out      (timed_out),
    .aborted        (aborted),
    .cycle_count    (cycle_count),
    .ctrl           (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > CMAX) return CMAX;
    return v;
  endfunction

  // {busy, done, write, read, writedata}
  function automatic logic [11:0] obs_word();
    return {busy, done, bus_if.ctrl_write, bus_if.ctrl_read, bus_if.ctrl_writedata};
  endfunction

  // Expected bus picture for cycle t of a run that halts (HALT write) in cycle h.
  function automatic logic [11:0] exp_word(input int t, input int h);
    logic       b, d, w, r;
    logic [7:0] wd;
    b  = (t <= h + 1);
    d  = (t == h + 1);
    w  = (t == 1) || (t == 2 && h > 2) || (t == h);
    wd = (t == 1) ? 8'h02 : ((t == 2 && h > 2) ? 8'h01 : 8'h00);
    r  = (t < h) && (t >= 3 + P) && (((t - 3 - P) % (P + 2)) == 0);
    return {b, d, w, r, wd};
  endfunction

  // k: read index that returns waiting=1 (0 = never); T: timeout; a: cycle abort is high (0 = none)
  task automatic run(input int k, input int T, input int a, input bit hold);
    int         h, e, c, rd_cnt;
    bit         ab, to, prev_read;
    logic [4:0] hi;
    logic [1:0] lo;
    h = 0; ab = 0; to = 0;
    for (int i = 1; i <= 4000 && h == 0; i++) begin
      e = 4 + P + (i - 1) * (P + 2);
      c = sat(P + 1 + (i - 1) * (P + 2));
      if (a != 0 && a <= e) begin h = a + 1; ab = 1; end
      else if (i == k) h = e + 1;
      else if (T != 0 && c >= T) begin h = e + 1; to = 1; end
    end
    start = 1'b1;
    timeout_cycles = CW'(T);
    abort = 1'b0;
    rd_cnt = 0;
    prev_read = 0;
    for (int t = 1; t <= h + 2; t++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      abort = (t == a);
      hi = 5'($urandom);
      lo = 2'($urandom);
      bus_if.ctrl_readdata = {hi, (prev_read && rd_cnt == k), lo};
      chk("bus_cycle", 32'(obs_word()), 32'(exp_word(t, h)));
      if (t == h) begin
        chk("aborted_at_halt", 32'(aborted), 32'(ab));
        chk("timed_out_at_halt", 32'(timed_out), 32'(to));
      end
      if (bus_if.ctrl_read) rd_cnt++;
      prev_read = bus_if.ctrl_read;
    end
    abort = 1'b0;
    chk("cycle_count", 32'(cycle_count), 32'(sat(h - 4)));
    chk("aborted_final", 32'(aborted), 32'(ab));
    chk("timed_out_final", 32'(timed_out), 32'(to));
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_bus", 32'(obs_word()), 32'h0);
    end
  endtask

  function automatic logic [31:0] reset_word();
    return {busy, done, timed_out, aborted, bus_if.ctrl_write, bus_if.ctrl_read,
            bus_if.ctrl_writedata, cycle_count};
  endfunction

  initial begin
    int k, T, a;
    bus_if.ctrl_readdata = 8'h00;
    #1;
    chk("reset_values", reset_word(), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    run(1, 0, 0, 0);  idle(3);   // waiting on first read
    run(3, 0, 0, 0);  idle(3);   // waiting on third read
    run(0, 10, 0, 0); idle(3);   // timeout after second poll
    run(0, 0, 5, 0);  idle(2);   // abort in GAP
    run(1, 0, 0, 0);  idle(2);   // flags cleared by next start
    run(0, 0, 1, 0);  idle(2);   // abort during reset write
    run(2, 0, 2, 0);  idle(2);   // abort during run write
    run(1, 0, 8, 0);  idle(2);   // abort beats waiting at evaluation
    run(2, 11, 0, 0); idle(2);   // waiting beats timeout on same poll
    run(0, 0, 300, 0); idle(2);  // counter saturation

    // asynchronous reset mid-GAP
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", reset_word(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("in_reset", reset_word(), 32'h0);
    end
    reset_n = 1'b1;
    idle(4);
    run(1, 0, 0, 0); idle(2);

    // start held high: back-to-back runs, no restart while busy
    run(1, 0, 0, 1);
    run(2, 0, 0, 0);
    idle(3);

    for (int n = 0; n < 25; n++) begin
      k = $urandom_range(0, 4);
      T = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 40) : 0;
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      if (k == 0 && T == 0 && a == 0) k = 1;
      run(k, T, a, 0);
      idle($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/creek_run_sequencer.md
# creek_run_sequencer

Host-side Avalon-MM master that drives the creek control adapter's 8-bit control/status register to run one creek program to completion. On a `start` pulse it pulses creek reset, releases pause, polls the waiting bit at a fixed interval, then re-pauses the core. It reports done, timeout, or abort status and the run length in cycles. It sits directly upstream of the control adapter, on the adapter's Avalon slave port. The adapter has no address bus and a fixed read latency of 1 cycle.

## Interface
Parameters:
- POLL_INTERVAL, 16, idle cycles between successive status reads (≥1)
- CNT_WIDTH, 32, width of cycle counter and timeout

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel the run in progress; ignored in IDLE, HALT_WR, DONE
- timeout_cycles  in  CNT_WIDTH  run limit; 0 = no limit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of any run
- timed_out  out  1  sticky status; cleared on the next accepted start
- aborted  out  1  sticky status; cleared on the next accepted start
- cycle_count  out  CNT_WIDTH  run length; frozen after the run
- ctrl_writedata  out  8  to adapter; bit0 = pause_n, bit1 = reset
- ctrl_write  out  1  to adapter write strobe
- ctrl_read  out  1  to adapter read strobe
- ctrl_readdata  in  8  from adapter; bit2 = creek_waiting; valid the cycle after ctrl_read

## Operation
- Registered FSM with states IDLE, RESET_WR, RUN_WR, GAP, POLL_RD, POLL_WAIT, HALT_WR, DONE.
- All outputs are registered. ctrl_write and ctrl_read are never high together.
- IDLE:
  - start=1 → RESET_WR.
  - On that transition, clear timed_out, aborted and cycle_count.
- RESET_WR: ctrl_write=1, data 0x02 (reset=1, pause_n=0). The adapter self-clears reset afterwards. → RUN_WR.
- RUN_WR: ctrl_write=1, data 0x01 (pause_n=1). → GAP with gap counter = POLL_INTERVAL-1.
- GAP: counts down; at 0 → POLL_RD.
- POLL_RD: ctrl_read=1 for one cycle. → POLL_WAIT.
- POLL_WAIT: evaluate ctrl_readdata in this priority order:
  1. abort → HALT_WR, set aborted.
  2. ctrl_readdata[2]=1 → HALT_WR.
  3. timeout_cycles≠0 and cycle_count ≥ timeout_cycles → HALT_WR, set timed_out.
  4. Otherwise → GAP.
- abort in RESET_WR, RUN_WR, GAP or POLL_RD:
  - The current state's bus action still completes.
  - Next state is HALT_WR; set aborted.
- HALT_WR: ctrl_write=1, data 0x00 (pause core). → DONE.
- DONE: done=1 for one cycle. → IDLE.
- cycle_count:
  - Increments by 1 on every clock edge while in GAP, POLL_RD or POLL_WAIT.
  - Saturates at all-ones and never wraps.
  - Frozen from HALT_WR onward. Reads 0 after reset.
- start while busy is ignored. The run is not restarted.

## Timing
- Reset values: busy=0, done=0, timed_out=0, aborted=0, cycle_count=0, ctrl_write=0, ctrl_read=0, ctrl_writedata=0x00, state IDLE.
- reset_n asserted mid-run forces all of the above immediately. No HALT_WR is issued.
- With start high in cycle 0 and P = POLL_INTERVAL:
  - Cycle 1: write 0x02.
  - Cycle 2: write 0x01.
  - Cycles 3..2+P: GAP.
  - Cycle 3+P: read.
  - Cycle 4+P: evaluate.
- If the evaluation in cycle 4+P halts the run:
  - Cycle 5+P: write 0x00.
  - Cycle 6+P: done=1.
  - cycle_count = P+1.
- Each additional poll adds P+2 cycles to the run and to cycle_count.
- busy rises the cycle after start is sampled and falls the cycle after done.
- timed_out and aborted become visible in HALT_WR and hold until the next accepted start.

## Test plan
- POLL_INTERVAL=4, adapter model returns waiting=1 on first read → writes 0x02@1, 0x01@2, read@7, 0x00@9, done@10, cycle_count=5, timed_out=0, aborted=0.
- POLL_INTERVAL=4, waiting goes to 1 only on the third read → reads at cycles 7, 13, 19; done@22; cycle_count=17.
- timeout_cycles=10, waiting never set → halts after second poll (cycle_count=11 ≥ 10); 0x00 written; done pulse; timed_out=1; aborted=0.
- abort asserted in a GAP cycle → HALT_WR next cycle with no further read; done pulse; aborted=1; then start again clears aborted and timed_out.
- reset_n pulsed low mid-GAP → all outputs return to reset values asynchronously; no ctrl_write afterwards; a subsequent start runs the normal sequence.
- start held high across a full run, with waiting=1 → a second run begins in the cycle after DONE; no start is accepted while busy=1.
